mips32_run_ctrl: RTL and testbench
==================================

MIPS32_RUN_CTRL -- requirements
Module: mips32_run_ctrl

Interface
REQ-001 Parameter DATA_W, 32, instruction/register word width.
REQ-002 Parameter IMEM_DEPTH, 1024, instruction memory words; AW = clog2(IMEM_DEPTH).
REQ-003 Parameter NREGS, 32, core register count; RW = clog2(NREGS).
REQ-004 Parameter DUMP_N, 4, registers dumped after halt (1..NREGS), starting at R0.
REQ-005 Parameter TIMEOUT_CYC, 4096, max RUN cycles before error.
REQ-006 One clock; reset is synchronous and active-high: clk1  in  1  sole clock, all state on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  one-cycle pulse, begins a load/run/dump session.
REQ-009 load_valid/load_ready  in/out  1  program-word handshake; load_data  in  DATA_W; load_last  in  1  final word.
REQ-010 imem_we  out  1; imem_addr  out  AW; imem_wdata  out  DATA_W  instruction-memory write port.
REQ-011 core_clr  out  1  one-cycle pulse: core sets pc=0, Taken_branch=0, Halted=0.
REQ-012 core_run  out  1  core enable; core_halted  in  1  core executed HLT.
REQ-013 reg_rd_addr  out  RW; reg_rd_data  in  DATA_W  register-bank read, 1-cycle latency.
REQ-014 dump_valid/dump_ready  out/in  1; dump_data  out  DATA_W; dump_idx  out  RW; dump_last  out  1.
REQ-015 busy, done, err_timeout, err_overflow  out  1  status.

Function
REQ-016 States SHALL be IDLE, LOAD, CLR, RUN, RD, WAIT, DUMP, DONE, ERR.
REQ-017 IDLE: start -> LOAD, word counter cleared; start ignored in all other states.
REQ-018 LOAD: load_ready=1; each load_valid&&load_ready writes load_data to imem_addr=counter same cycle (imem_we=1), counter+1.
REQ-019 Handshake with load_last -> CLR; handshake at counter=IMEM_DEPTH-1 without load_last -> ERR with err_overflow=1 (word written).
REQ-020 CLR: core_clr=1 exactly one cycle, then RUN.
REQ-021 RUN: core_run=1, cycle counter increments; core_halted=1 -> RD, core_run=0 next cycle; counter reaching TIMEOUT_CYC -> ERR with err_timeout=1.
REQ-022 core_halted and timeout in the same cycle SHALL resolve to RD (halt wins).
REQ-023 RD drives reg_rd_addr=dump index; WAIT captures reg_rd_data into dump_data register.
REQ-024 DUMP: dump_valid=1; dump_data/dump_idx/dump_last stable until dump_ready; dump_last=1 when index=DUMP_N-1.
REQ-025 DUMP transfer: index<DUMP_N-1 -> index+1, RD; else DONE.
REQ-026 DONE/ERR: done (or err flag) held 1 until next start, which returns to LOAD and clears all flags.
REQ-027 busy=1 in LOAD, CLR, RUN, RD, WAIT, DUMP.
REQ-028 Counters SHALL never wrap; index width RW, cycle counter width clog2(TIMEOUT_CYC+1).

Reset
REQ-029 rst SHALL force IDLE and all outputs to 0 next edge, from any state, including mid-LOAD or mid-DUMP; a partly loaded program is not resumed.
REQ-030 rst has priority over start and every handshake in the same cycle.

Structure
REQ-031 Shared package mips32_pkg SHALL hold the state enumeration, HLT opcode constant 6'h3f and default parameter constants.
REQ-032 One sub-module mips32_ctr (parametrised width, clear/enable/terminal flag) SHALL be used for word, cycle and dump counters; no other hierarchy.

Verification
REQ-033 Load 6 words (ADDI R1,R0,5; ADDI R2,R0,5; 2x OR R7,R7,R7; ADD R3,R1,R2; HLT), core model halts -> dump 0,5,5,10, idx 0..3, last on idx 3, done=1.
REQ-034 dump_ready low 3 cycles per word -> dump_data/idx unchanged while stalled, no word lost or duplicated.
REQ-035 IMEM_DEPTH=8, 9 words without load_last -> 8 writes, err_overflow=1, core_clr never pulsed.
REQ-036 TIMEOUT_CYC=16, core_halted held 0 -> core_run high exactly 16 cycles, err_timeout=1, no dump.
REQ-037 rst asserted mid-DUMP after 2 words -> IDLE, dump_valid=0 next cycle; new start reloads and dumps from R0.
REQ-038 core_halted rises on timeout cycle -> normal dump, err_timeout=0.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 load/run/dump controller: sequencer states,
// the halt opcode and default sizing.
package mips32_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLR,
    ST_RUN,
    ST_RD,
    ST_WAIT,
    ST_DUMP,
    ST_DONE,
    ST_ERR
  } run_state_e;

  localparam logic [5:0] OP_HLT = 6'h3f;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_IMEM_DEPTH  = 1024;
  localparam int DEF_NREGS       = 32;
  localparam int DEF_DUMP_N      = 4;
  localparam int DEF_TIMEOUT_CYC = 4096;

  // Address width that stays at least one bit for degenerate depths.
  function automatic int aw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mips32_run_ctrl_if.sv
// Bus bundle between the run controller (master) and its environment:
// program load, imem write port, core control, register read and dump stream.
interface mips32_run_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 10,
  parameter int RW     = 5
);
  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_last;

  logic              imem_we;
  logic [AW-1:0]     imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  logic              core_clr;
  logic              core_run;
  logic              core_halted;

  logic [RW-1:0]     reg_rd_addr;
  logic [DATA_W-1:0] reg_rd_data;

  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [RW-1:0]     dump_idx;
  logic              dump_last;

  modport master (
    input  load_valid, load_data, load_last, core_halted, reg_rd_data, dump_ready,
    output load_ready, imem_we, imem_addr, imem_wdata, core_clr, core_run,
           reg_rd_addr, dump_valid, dump_data, dump_idx, dump_last
  );

  modport slave (
    output load_valid, load_data, load_last, core_halted, reg_rd_data, dump_ready,
    input  load_ready, imem_we, imem_addr, imem_wdata, core_clr, core_run,
           reg_rd_addr, dump_valid, dump_data, dump_idx, dump_last
  );
endinterface

// File: rtl/mips32_ctr.sv
// Saturating up-counter with synchronous clear; term flags the last value so
// callers can act on it without the count ever wrapping.
module mips32_ctr #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk1,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  assign term = (cnt == MAX);

  always_ff @(posedge clk1) begin
    if (rst || clr)      cnt <= '0;
    else if (en && !term) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/mips32_run_ctrl.sv
// Session sequencer for a MIPS32 core: loads a program into imem, clears and
// runs the core until HLT or timeout, then streams the first DUMP_N registers.
module mips32_run_ctrl
  import mips32_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IMEM_DEPTH  = DEF_IMEM_DEPTH,
  parameter int NREGS       = DEF_NREGS,
  parameter int DUMP_N      = DEF_DUMP_N,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic               start,
  mips32_run_ctrl_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic               err_overflow
);

  localparam int AW = aw_of(IMEM_DEPTH);
  localparam int RW = aw_of(NREGS);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  run_state_e    state;
  logic          start_ok;
  logic          wr_hs;
  logic          dump_hs;
  logic [AW-1:0] word_cnt;
  logic          word_term;
  logic [CW-1:0] cyc_cnt_unused;
  logic          cyc_term;
  logic [RW-1:0] didx;
  logic          dump_term;

  assign start_ok = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign wr_hs    = (state == ST_LOAD) && bus.load_valid && bus.load_ready;
  assign dump_hs  = (state == ST_DUMP) && bus.dump_valid && bus.dump_ready;

  mips32_ctr #(.W(AW), .MAX(AW'(IMEM_DEPTH - 1))) u_word_ctr (
    .clk1 (clk1),
    .rst  (rst),
    .clr  (start_ok),
    .en   (wr_hs),
    .cnt  (word_cnt),
    .term (word_term)
  );

  // Counting already in CLR puts the count at k during the k-th RUN cycle, so
  // term lands exactly on the TIMEOUT_CYC-th cycle with core_run high.
  mips32_ctr #(.W(CW), .MAX(CW'(TIMEOUT_CYC))) u_cyc_ctr (
    .clk1 (clk1),
    .rst  (rst),
    .clr  (start_ok),
    .en   (state == ST_CLR || state == ST_RUN),
    .cnt  (cyc_cnt_unused),
    .term (cyc_term)
  );

  mips32_ctr #(.W(RW), .MAX(RW'(DUMP_N - 1))) u_dump_ctr (
    .clk1 (clk1),
    .rst  (rst),
    .clr  (start_ok),
    .en   (dump_hs),
    .cnt  (didx),
    .term (dump_term)
  );

  // imem write is combinational so the word lands in the handshake cycle.
  assign bus.imem_we     = wr_hs;
  assign bus.imem_addr   = word_cnt;
  assign bus.imem_wdata  = wr_hs ? bus.load_data : '0;
  assign bus.reg_rd_addr = didx;
  assign bus.dump_idx    = didx;
  assign bus.dump_last   = bus.dump_valid && dump_term;

  assign busy = (state inside {ST_LOAD, ST_CLR, ST_RUN, ST_RD, ST_WAIT, ST_DUMP});

  always_ff @(posedge clk1) begin
    if (rst) begin
      state          <= ST_IDLE;
      bus.load_ready <= 1'b0;
      bus.core_clr   <= 1'b0;
      bus.core_run   <= 1'b0;
      bus.dump_valid <= 1'b0;
      bus.dump_data  <= '0;
      done           <= 1'b0;
      err_timeout    <= 1'b0;
      err_overflow   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state          <= ST_LOAD;
            bus.load_ready <= 1'b1;
            done           <= 1'b0;
            err_timeout    <= 1'b0;
            err_overflow   <= 1'b0;
          end
        end
        ST_LOAD: begin
          // A last word in the final slot still counts as a complete program.
          if (wr_hs) begin
            if (bus.load_last) begin
              state          <= ST_CLR;
              bus.load_ready <= 1'b0;
              bus.core_clr   <= 1'b1;
            end else if (word_term) begin
              state          <= ST_ERR;
              bus.load_ready <= 1'b0;
              err_overflow   <= 1'b1;
            end
          end
        end
        ST_CLR: begin
          bus.core_clr <= 1'b0;
          bus.core_run <= 1'b1;
          state        <= ST_RUN;
        end
        ST_RUN: begin
          // Halt is checked first so a halt on the timeout cycle still dumps.
          if (bus.core_halted) begin
            bus.core_run <= 1'b0;
            state        <= ST_RD;
          end else if (cyc_term) begin
            bus.core_run <= 1'b0;
            err_timeout  <= 1'b1;
            state        <= ST_ERR;
          end
        end
        ST_RD: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          bus.dump_data  <= bus.reg_rd_data;
          bus.dump_valid <= 1'b1;
          state          <= ST_DUMP;
        end
        ST_DUMP: begin
          if (bus.dump_ready) begin
            bus.dump_valid <= 1'b0;
            if (dump_term) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_RD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_run_ctrl.sv
// Bench for mips32_run_ctrl: small MIPS core/regfile model, expected dump
// beats queued per session and checked as the stream is accepted.
module tb_mips32_run_ctrl;
  import mips32_pkg::*;

  logic clk1 = 1'b0;
  logic rst;
  logic start;
  logic busy, done, err_timeout, err_overflow;

  always #5 clk1 = ~clk1;

  mips32_run_ctrl_if #(.DATA_W(32), .AW(3), .RW(5)) u_if ();

  mips32_run_ctrl #(
    .DATA_W(32), .IMEM_DEPTH(8), .NREGS(32), .DUMP_N(4), .TIMEOUT_CYC(16)
  ) u_dut (
    .clk1         (clk1),
    .rst          (rst),
    .start        (start),
    .bus          (u_if.master),
    .busy         (busy),
    .done         (done),
    .err_timeout  (err_timeout),
    .err_overflow (err_overflow)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   exp_v [4] = '{0, 5, 5, 10};

  task automatic push4();
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.idx  = 5'(i);
      e.data = 32'(exp_v[i]);
      e.last = (i == 3);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- core / regfile model ----------------
  logic [31:0] imem [8];
  logic [31:0] regs [32];
  logic [2:0]  pc;
  logic        m_halted;
  logic [31:0] cur;
  int          hmode = 0;   // 0 model halt, 1 never halt, 2 halt on 16th run cycle
  int          run_cnt = 0;
  int          n_we = 0, n_clr = 0, n_dv = 0;

  assign cur = imem[pc];
  assign u_if.core_halted = (hmode == 2) ? (u_if.core_run && run_cnt == 15) :
                            (hmode == 1) ? 1'b0 : m_halted;

  always @(posedge clk1) begin
    u_if.reg_rd_data <= regs[u_if.reg_rd_addr];
    if (u_if.imem_we) imem[u_if.imem_addr] <= u_if.imem_wdata;
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      pc       <= '0;
      m_halted <= 1'b0;
    end else if (u_if.core_clr) begin
      pc       <= '0;
      m_halted <= 1'b0;
    end else if (u_if.core_run && !m_halted) begin
      pc <= pc + 3'd1;
      case (cur[31:26])
        6'h08:  if (cur[20:16] != 0) regs[cur[20:16]] <= regs[cur[25:21]] + {{16{cur[15]}}, cur[15:0]};
        6'h00: begin
          if (cur[15:11] != 0) begin
            if (cur[5:0] == 6'h20) regs[cur[15:11]] <= regs[cur[25:21]] + regs[cur[20:16]];
            if (cur[5:0] == 6'h25) regs[cur[15:11]] <= regs[cur[25:21]] | regs[cur[20:16]];
          end
        end
        OP_HLT: m_halted <= 1'b1;
        default: ;
      endcase
    end
  end

  always @(posedge clk1) begin
    if (u_if.core_clr)      run_cnt <= 0;
    else if (u_if.core_run) run_cnt <= run_cnt + 1;
    n_we  <= n_we  + int'(u_if.imem_we);
    n_clr <= n_clr + int'(u_if.core_clr);
    n_dv  <= n_dv  + int'(u_if.dump_valid);
  end

  // ---------------- dump sink / scoreboard ----------------
  int          n_dump = 0;
  int          dump_stop_at = 1 << 30;
  bit          stall_en = 1'b0;
  int          stall_n = 0;
  logic [31:0] held_d;
  logic [4:0]  held_i;
  exp_t        d_e;

  always @(negedge clk1) begin
    if (u_if.dump_valid && n_dump < dump_stop_at) begin
      if (stall_en && stall_n > 0) begin
        chk("stall_data", u_if.dump_data, held_d);
        chk("stall_idx", 32'(u_if.dump_idx), 32'(held_i));
      end
      if (stall_en && stall_n < 3) begin
        if (stall_n == 0) begin
          held_d = u_if.dump_data;
          held_i = u_if.dump_idx;
        end
        stall_n++;
        u_if.dump_ready = 1'b0;
      end else begin
        u_if.dump_ready = 1'b1;
        stall_n = 0;
        n_dump++;
        if (exp_q.size() == 0) begin
          chk("dump_extra", 32'(u_if.dump_idx), 32'hffff_ffff);
        end else begin
          d_e = exp_q.pop_front();
          chk("dump_idx", 32'(u_if.dump_idx), 32'(d_e.idx));
          chk("dump_data", u_if.dump_data, d_e.data);
          chk("dump_last", 32'(u_if.dump_last), 32'(d_e.last));
        end
      end
    end else begin
      u_if.dump_ready = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] prog [6];

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic send_word(input logic [31:0] d, input logic l, output bit ok);
    int n = 0;
    ok = 1'b0;
    @(negedge clk1);
    u_if.load_valid = 1'b1;
    u_if.load_data  = d;
    u_if.load_last  = l;
    while (!u_if.load_ready && n < 20) begin
      @(negedge clk1);
      n++;
    end
    if (u_if.load_ready) begin
      @(posedge clk1);
      ok = 1'b1;
    end
    #1;
    u_if.load_valid = 1'b0;
    u_if.load_last  = 1'b0;
  endtask

  task automatic start_sess();
    @(negedge clk1);
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_done_clr", 32'(done), 0);
    chk("start_errt_clr", 32'(err_timeout), 0);
    chk("start_erro_clr", 32'(err_overflow), 0);
  endtask

  task automatic load_prog();
    bit ok;
    for (int i = 0; i < 6; i++) begin
      send_word(prog[i], i == 5, ok);
      chk("load_ok", 32'(ok), 1);
    end
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || err_timeout || err_overflow) && n < 400) begin
      @(negedge clk1);
      n++;
    end
    chk("end_reached", 32'(done || err_timeout || err_overflow), 1);
  endtask

  initial begin
    bit ok;
    int we0, clr0, dv0, stop;
    rst = 1'b1;
    start = 1'b0;
    u_if.load_valid = 1'b0;
    u_if.load_data  = '0;
    u_if.load_last  = 1'b0;
    prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
    prog[2] = enc_r(5'd7, 5'd7, 5'd7, 6'h25);
    prog[3] = enc_r(5'd7, 5'd7, 5'd7, 6'h25);
    prog[4] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    prog[5] = {OP_HLT, 26'd0};

    repeat (3) @(negedge clk1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_errt", 32'(err_timeout), 0);
    chk("rst_erro", 32'(err_overflow), 0);
    chk("rst_load_ready", 32'(u_if.load_ready), 0);
    chk("rst_core_clr", 32'(u_if.core_clr), 0);
    chk("rst_core_run", 32'(u_if.core_run), 0);
    chk("rst_dump_valid", 32'(u_if.dump_valid), 0);
    chk("rst_imem_we", 32'(u_if.imem_we), 0);
    chk("rst_dump_idx", 32'(u_if.dump_idx), 0);
    rst = 1'b0;

    // Basic program: dump 0,5,5,10
    we0 = n_we; clr0 = n_clr;
    push4();
    start_sess();
    load_prog();
    wait_end();
    chk("a_done", 32'(done), 1);
    chk("a_errt", 32'(err_timeout), 0);
    chk("a_busy", 32'(busy), 0);
    chk("a_q_left", 32'(exp_q.size()), 0);
    chk("a_clr_pulses", 32'(n_clr - clr0), 1);
    chk("a_writes", 32'(n_we - we0), 6);
    chk("a_core_run", 32'(u_if.core_run), 0);
    repeat (3) @(negedge clk1);
    chk("a_done_held", 32'(done), 1);

    // Same program with a 3-cycle stall on each dump word
    stall_en = 1'b1;
    push4();
    start_sess();
    load_prog();
    wait_end();
    stall_en = 1'b0;
    chk("b_done", 32'(done), 1);
    chk("b_q_left", 32'(exp_q.size()), 0);

    // Core never halts: timeout after exactly 16 run cycles, no dump
    hmode = 1;
    dv0 = n_dv;
    start_sess();
    load_prog();
    wait_end();
    chk("c_errt", 32'(err_timeout), 1);
    chk("c_done", 32'(done), 0);
    chk("c_run_cycles", 32'(run_cnt), 16);
    chk("c_no_dump", 32'(n_dv - dv0), 0);
    chk("c_core_run", 32'(u_if.core_run), 0);

    // Halt on the timeout cycle: halt wins, normal dump
    hmode = 2;
    push4();
    start_sess();
    load_prog();
    wait_end();
    hmode = 0;
    chk("d_done", 32'(done), 1);
    chk("d_errt", 32'(err_timeout), 0);
    chk("d_run_cycles", 32'(run_cnt), 16);
    chk("d_q_left", 32'(exp_q.size()), 0);

    // Overflow: 9 words, no load_last, depth 8
    we0 = n_we; clr0 = n_clr;
    start_sess();
    for (int i = 0; i < 9; i++) begin
      send_word(32'h0000_00a0 + 32'(i), 1'b0, ok);
      chk("e_word_accept", 32'(ok), (i < 8) ? 32'd1 : 32'd0);
    end
    chk("e_erro", 32'(err_overflow), 1);
    chk("e_writes", 32'(n_we - we0), 8);
    chk("e_no_clr", 32'(n_clr - clr0), 0);
    chk("e_busy", 32'(busy), 0);
    chk("e_done", 32'(done), 0);

    // Reset in the middle of the dump after two words
    stop = n_dump + 2;
    dump_stop_at = stop;
    push4();
    start_sess();
    load_prog();
    begin
      int n = 0;
      while (!(u_if.dump_valid && n_dump == stop) && n < 300) begin
        @(posedge clk1);
        #1;
        n++;
      end
    end
    chk("f_mid_dump", 32'(u_if.dump_valid && n_dump == stop), 1);
    @(negedge clk1);
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    chk("f_dump_valid", 32'(u_if.dump_valid), 0);
    chk("f_busy", 32'(busy), 0);
    chk("f_dump_idx", 32'(u_if.dump_idx), 0);
    chk("f_core_run", 32'(u_if.core_run), 0);
    chk("f_q_left", 32'(exp_q.size()), 2);
    exp_q.delete();
    dump_stop_at = 1 << 30;

    // Fresh session after reset reloads and dumps from R0
    push4();
    start_sess();
    load_prog();
    wait_end();
    chk("g_done", 32'(done), 1);
    chk("g_q_left", 32'(exp_q.size()), 0);

    repeat (2) @(negedge clk1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
